// File: rtl/alu_pipe_if.sv
// Operand/result bus between the operand source and alu_pipe_core.
// The source drives the master side and the core implements the slave side.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       S;
    logic [WIDTH-1:0] F;
    logic             out_valid;
    logic             z;
    logic             c;
    logic             o;
    logic             G;
    logic             L;
    logic             E;

    modport master (
        output in_valid, A, B, S,
        input  in_ready, F, out_valid, z, c, o, G, L, E
    );

    modport slave (
        input  in_valid, A, B, S,
        output in_ready, F, out_valid, z, c, o, G, L, E
    );
endinterface

// File: rtl/alu_pipe_core.sv
// Registered ALU with a valid/ready operand handshake, a sticky carry for ADC/SBB
// and an iterative shift-add multiply that holds in_ready low while it runs.
module alu_pipe_core #(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    alu_pipe_if.slave bus
);
    localparam int W  = WIDTH;
    localparam int LW = $clog2(WIDTH);

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     f_q, f_d;
    logic             z_q, z_d, c_q, c_d, o_q, o_d;
    logic             g_q, g_d, l_q, l_d, e_q, e_d;
    logic             vld_q, vld_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   mcand_q, mcand_d, acc_q, acc_d, acc_step;
    logic [W-1:0]     mplr_q, mplr_d;

    logic             accept;
    logic             cin;
    logic [LW-1:0]    sh_n;
    logic [W:0]       add_w, sub_w, inc_w, dec_w;
    logic [W:0]       shl_w, shr_w, sar_w;
    logic [2*W-1:0]   rol_w;
    logic [W-1:0]     alu_f;
    logic             alu_c, alu_o, alu_wr;

    function automatic logic [2:0] compare_gle(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] a_s;
        logic signed [W-1:0] b_s;
        a_s = a;
        b_s = b;
        if (SIGNED_CMP) return {a_s > b_s, a_s < b_s, a == b};
        return {a > b, a < b, a == b};
    endfunction

    // Signed overflow of a sum: operands agree in sign, result does not.
    function automatic logic sum_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    assign accept = bus.in_valid && (state_q == ST_IDLE);
    assign sh_n   = bus.B[LW-1:0];
    assign cin    = (bus.S == 4'd2 || bus.S == 4'd3) ? c_q : 1'b0;
    assign add_w  = {1'b0, bus.A} + {1'b0, bus.B} + {{W{1'b0}}, cin};
    assign sub_w  = {1'b0, bus.A} - {1'b0, bus.B} - {{W{1'b0}}, cin};
    assign inc_w  = {1'b0, bus.A} + {{W{1'b0}}, 1'b1};
    assign dec_w  = {1'b0, bus.A} - {{W{1'b0}}, 1'b1};
    // The extra bit on each shift captures the last bit shifted out (0 when n = 0).
    assign shl_w  = {1'b0, bus.A} << sh_n;
    assign shr_w  = {bus.A, 1'b0} >> sh_n;
    assign sar_w  = $unsigned($signed({bus.A, 1'b0}) >>> sh_n);
    assign rol_w  = {{W{1'b0}}, bus.A} << sh_n;
    assign acc_step = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        alu_f  = f_q;
        alu_c  = 1'b0;
        alu_o  = 1'b0;
        alu_wr = 1'b1;
        case (bus.S)
            4'd0, 4'd2: begin
                alu_f = add_w[W-1:0];
                alu_c = add_w[W];
                alu_o = sum_ovf(bus.A[W-1], bus.B[W-1], add_w[W-1]);
            end
            4'd1, 4'd3: begin
                alu_f = sub_w[W-1:0];
                alu_c = sub_w[W];
                alu_o = sum_ovf(bus.A[W-1], ~bus.B[W-1], sub_w[W-1]);
            end
            4'd4: alu_f = bus.A & bus.B;
            4'd5: alu_f = bus.A | bus.B;
            4'd6: alu_f = bus.A ^ bus.B;
            4'd7: alu_f = ~bus.A;
            4'd8: begin
                alu_f = shl_w[W-1:0];
                alu_c = shl_w[W];
            end
            4'd9: begin
                alu_f = shr_w[W:1];
                alu_c = shr_w[0];
            end
            4'd10: begin
                alu_f = sar_w[W:1];
                alu_c = sar_w[0];
            end
            4'd11: begin
                alu_f = rol_w[2*W-1:W] | rol_w[W-1:0];
                alu_c = rol_w[W] | rol_w[0];
            end
            4'd12: begin
                alu_f = inc_w[W-1:0];
                alu_c = inc_w[W];
                alu_o = sum_ovf(bus.A[W-1], 1'b0, inc_w[W-1]);
            end
            4'd13: begin
                alu_f = dec_w[W-1:0];
                alu_c = dec_w[W];
                alu_o = sum_ovf(bus.A[W-1], 1'b1, dec_w[W-1]);
            end
            default: alu_wr = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        z_d     = z_q;
        c_d     = c_q;
        o_d     = o_q;
        g_d     = g_q;
        l_d     = l_q;
        e_d     = e_q;
        vld_d   = 1'b0;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    {g_d, l_d, e_d} = compare_gle(bus.A, bus.B);
                    if (bus.S == 4'd14) begin
                        state_d = ST_MUL;
                        mcand_d = {{W{1'b0}}, bus.A};
                        mplr_d  = bus.B;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        vld_d = 1'b1;
                        if (alu_wr) begin
                            f_d = alu_f;
                            z_d = (alu_f == '0);
                            c_d = alu_c;
                            o_d = alu_o;
                        end
                    end
                end
            end
            ST_MUL: begin
                // One multiplier bit per edge; the last iteration writes the result directly.
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LW'(W - 1)) begin
                    state_d = ST_IDLE;
                    vld_d   = 1'b1;
                    f_d     = acc_step[W-1:0];
                    z_d     = (acc_step[W-1:0] == '0);
                    c_d     = |acc_step[2*W-1:W];
                    o_d     = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            f_q     <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            o_q     <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            z_q     <= z_d;
            c_q     <= c_d;
            o_q     <= o_d;
            g_q     <= g_d;
            l_q     <= l_d;
            e_q     <= e_d;
            vld_q   <= vld_d;
        end
    end

    // Multiplier working registers are reloaded on every MUL accept and need no reset.
    always_ff @(posedge clk) begin
        cnt_q   <= cnt_d;
        mcand_q <= mcand_d;
        mplr_q  <= mplr_d;
        acc_q   <= acc_d;
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.F         = f_q;
    assign bus.out_valid = vld_q;
    assign bus.z         = z_q;
    assign bus.c         = c_q;
    assign bus.o         = o_q;
    assign bus.G         = g_q;
    assign bus.L         = l_q;
    assign bus.E         = e_q;
endmodule

// File: tb/tb_alu_pipe_core.sv
// Bench for alu_pipe_core: directed cases plus random operations against an
// integer-arithmetic reference model of the ALU rules.
module tb_alu_pipe_core;
    localparam int     W    = 8;
    localparam longint M    = 256;
    localparam bit     SCMP = 1'b0;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [7:0] mF;
    bit         mz, mc, mo, mG, mL, mE;

    alu_pipe_if #(.WIDTH(W)) bus();

    alu_pipe_core #(.WIDTH(W), .SIGNED_CMP(SCMP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] obs();
        return {bus.out_valid, bus.F, bus.z, bus.c, bus.o, bus.G, bus.L, bus.E};
    endfunction

    function automatic logic [14:0] model_vec();
        return {1'b1, mF, mz, mc, mo, mG, mL, mE};
    endfunction

    function automatic void model_reset();
        mF = 8'h00;
        {mz, mc, mo, mG, mL, mE} = 6'b0;
    endfunction

    // Reference behaviour computed with plain signed/unsigned integer arithmetic.
    function automatic void model_apply(input longint a, input longint b, input int s);
        longint sa, sb, res, sres, cin;
        int     n;
        bit     ovf_op;
        sa     = (a >= M / 2) ? a - M : a;
        sb     = (b >= M / 2) ? b - M : b;
        n      = int'(b % W);
        cin    = mc ? 1 : 0;
        res    = 0;
        sres   = 0;
        ovf_op = 1'b0;
        if (SCMP) begin
            mG = sa > sb; mL = sa < sb; mE = sa == sb;
        end else begin
            mG = a > b;   mL = a < b;   mE = a == b;
        end
        case (s)
            0:  begin res = a + b;       mc = res >= M; sres = sa + sb;       ovf_op = 1; end
            1:  begin res = a - b;       mc = a < b;    sres = sa - sb;       ovf_op = 1; end
            2:  begin res = a + b + cin; mc = res >= M; sres = sa + sb + cin; ovf_op = 1; end
            3:  begin res = a - b - cin; mc = res < 0;  sres = sa - sb - cin; ovf_op = 1; end
            4:  begin res = a & b; mc = 0; end
            5:  begin res = a | b; mc = 0; end
            6:  begin res = a ^ b; mc = 0; end
            7:  begin res = (M - 1) - a; mc = 0; end
            8:  begin res = a << n;  mc = (n != 0) && (((a >> (W - n)) & 1) != 0); end
            9:  begin res = a >> n;  mc = (n != 0) && (((a >> (n - 1)) & 1) != 0); end
            10: begin res = sa >>> n; mc = (n != 0) && (((a >> (n - 1)) & 1) != 0); end
            11: begin res = (a << n) | (a >> (W - n)); mc = (res & 1) != 0; end
            12: begin res = a + 1; mc = res >= M; sres = sa + 1; ovf_op = 1; end
            13: begin res = a - 1; mc = a == 0;   sres = sa - 1; ovf_op = 1; end
            14: begin res = a * b; mc = res >= M; end
            default: return;
        endcase
        mF = res[7:0];
        mz = (mF == 8'h00);
        mo = ovf_op && (sres < -(M / 2) || sres > (M / 2 - 1));
    endfunction

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.S        = s;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        model_apply(longint'(a), longint'(b), int'(s));
    endtask

    task automatic test_reset();
        logic [14:0] g;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.S = '0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.A = 8'h01; bus.B = 8'h01; bus.S = 4'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        model_reset();
        g = obs();
        n_cmp++;
        if (g !== 15'h0000) begin
            n_fail++;
            $display("FAIL reset_state: got %h, expected 0000 (vld,F,zcoGLE)", g);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, expected 1", bus.in_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_overrides_accept: out_valid got %b, expected 0", bus.out_valid);
        end
    endtask

    task automatic test_directed();
        logic [14:0] g;
        issue(8'h55, 8'h7F, 4'd0);
        g = obs();
        n_cmp++;
        if (g !== {1'b1, 8'hD4, 6'b001010}) begin
            n_fail++;
            $display("FAIL add_55_7f: got %h, expected %h", g, {1'b1, 8'hD4, 6'b001010});
        end
        issue(8'h7F, 8'h7F, 4'd1);
        g = obs();
        n_cmp++;
        if (g !== {1'b1, 8'h00, 6'b100001}) begin
            n_fail++;
            $display("FAIL sub_equal: got %h, expected %h", g, {1'b1, 8'h00, 6'b100001});
        end
        issue(8'h10, 8'h20, 4'd15);
        g = obs();
        n_cmp++;
        if (g !== {1'b1, 8'h00, 6'b100010}) begin
            n_fail++;
            $display("FAIL cmp_hold: got %h, expected %h", g, {1'b1, 8'h00, 6'b100010});
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: out_valid got %b, expected 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] g;
        issue(8'hFF, 8'h01, 4'd0);
        g = obs();
        n_cmp++;
        if (g !== {1'b1, 8'h00, 6'b110100}) begin
            n_fail++;
            $display("FAIL add_carry: got %h, expected %h", g, {1'b1, 8'h00, 6'b110100});
        end
        issue(8'h01, 8'h01, 4'd2);
        g = obs();
        n_cmp++;
        if (g !== {1'b1, 8'h03, 6'b000001}) begin
            n_fail++;
            $display("FAIL adc_chain: got %h, expected %h", g, {1'b1, 8'h03, 6'b000001});
        end
    endtask

    task automatic test_shifts();
        logic [14:0] g;
        issue(8'hC4, 8'h02, 4'd10);
        g = obs();
        n_cmp++;
        if (g !== {1'b1, 8'hF1, 6'b000100}) begin
            n_fail++;
            $display("FAIL sar_c4_2: got %h, expected %h", g, {1'b1, 8'hF1, 6'b000100});
        end
        issue(8'h81, 8'h09, 4'd8);
        g = obs();
        n_cmp++;
        if (g !== {1'b1, 8'h02, 6'b010100}) begin
            n_fail++;
            $display("FAIL shl_81_n1: got %h, expected %h", g, {1'b1, 8'h02, 6'b010100});
        end
    endtask

    task automatic test_mul();
        logic [14:0] g;
        logic [7:0]  a, b;
        int          low_cnt, early_vld;
        for (int k = 0; k < 8; k++) begin
            a = (k == 0) ? 8'hC4 : (k == 1) ? 8'h0F : 8'($urandom_range(0, 255));
            b = (k == 0) ? 8'h7F : (k == 1) ? 8'h11 : 8'($urandom_range(0, 255));
            issue(a, b, 4'd14);
            low_cnt   = 0;
            early_vld = 0;
            for (int i = 0; i < W; i++) begin
                if (bus.in_ready === 1'b0) low_cnt++;
                if (bus.out_valid !== 1'b0) early_vld++;
                if (k == 0 && i == 2) begin
                    bus.in_valid = 1'b1; bus.A = 8'h01; bus.B = 8'h02; bus.S = 4'd0;
                end
                if (k == 0 && i == 3) bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            n_cmp++;
            if (low_cnt != W || early_vld != 0 || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL mul_busy: ready-low cycles %0d early out_valid %0d ready-after %b, expected %0d 0 1",
                         low_cnt, early_vld, bus.in_ready, W);
            end
            g = obs();
            n_cmp++;
            if (g !== model_vec()) begin
                n_fail++;
                $display("FAIL mul_result a=%h b=%h: got %h, expected %h", a, b, g, model_vec());
            end
            if (k < 2) begin
                n_cmp++;
                if (g !== ((k == 0) ? {1'b1, 8'h3C, 6'b010100} : {1'b1, 8'hFF, 6'b000010})) begin
                    n_fail++;
                    $display("FAIL mul_directed k=%0d: got %h", k, g);
                end
            end
            @(posedge clk); #1;
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_single_pulse: out_valid got %b, expected 0", bus.out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [14:0] g;
        logic [3:0]  s;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                n_cmp++;
                if (bus.out_valid !== 1'b0 || bus.F !== mF || bus.c !== mc) begin
                    n_fail++;
                    $display("FAIL idle_hold: vld=%b F=%h c=%b, expected vld=0 F=%h c=%b",
                             bus.out_valid, bus.F, bus.c, mF, mc);
                end
            end else begin
                s = 4'($urandom_range(0, 15));
                if (s == 4'd14) s = 4'd15;
                issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), s);
                g = obs();
                n_cmp++;
                if (g !== model_vec() || bus.in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_op S=%0d A=%h B=%h: got %h ready=%b, expected %h ready=1",
                             s, bus.A, bus.B, g, bus.in_ready, model_vec());
                end
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [14:0] g;
        int          vld_seen;
        issue(8'hC4, 8'h7F, 4'd14);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        g = obs();
        n_cmp++;
        if (g !== 15'h0000 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_mul: got %h ready=%b, expected 0000 ready=1", g, bus.in_ready);
        end
        vld_seen = 0;
        for (int i = 0; i < W + 2; i++) begin
            if (bus.out_valid !== 1'b0) vld_seen++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (vld_seen != 0) begin
            n_fail++;
            $display("FAIL aborted_mul_no_valid: out_valid seen %0d times, expected 0", vld_seen);
        end
        issue(8'h12, 8'h34, 4'd0);
        g = obs();
        n_cmp++;
        if (g !== model_vec() || g !== {1'b1, 8'h46, 6'b000010}) begin
            n_fail++;
            $display("FAIL add_after_reset: got %h, expected %h", g, {1'b1, 8'h46, 6'b000010});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_shifts();
        test_mul();
        test_random();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
